// File: rtl/rf_pkg.sv
// Shared types for the register-file write arbiter: write record and x0 helper.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  // One pending register-file write: destination index plus result.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  // x0 is hard-wired zero, so any write aimed at it is meaningless.
  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/rf_sync_fifo.sv
// Small synchronous FIFO of rf_wr_t records buffering long-latency results.
// Push while full is accepted only when a pop happens in the same cycle.
module rf_sync_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  rf_wr_t wdata_i,
  input  logic   pop_i,
  output rf_wr_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  rf_wr_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writebacks and buffered long-latency results onto the
// single register-file write port, tracks outstanding long-latency
// destinations for the decode stall, and holds the pipeline off when the
// FIFO head has waited too long.
module rf_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_hold,
  input  logic            lw_valid,
  output logic            lw_ready,
  input  logic [4:0]      lw_rd,
  input  logic [XLEN-1:0] lw_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic            write_reg,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data
);

  import rf_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_HOLD = SW'(STARVE_MAX - 1);

  rf_wr_t            lw_wr, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              take_wb;
  logic [31:0]       pending_q, pending_d, set_mask, clr_mask;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wb_hold_q, wb_hold_d;
  logic              write_reg_q, write_reg_d;
  logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;

  // x0 results are acknowledged but never occupy a FIFO slot.
  assign lw_ready  = ~fifo_full & ~reset;
  assign fifo_push = lw_valid & lw_ready & ~is_x0(lw_rd);
  assign lw_wr     = '{rd: lw_rd, data: lw_data};

  rf_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (lw_wr),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Write-port selection: starved FIFO head, then pipeline, then FIFO.
  // A writeback arriving while held is a protocol error and is dropped.
  always_comb begin
    take_wb     = wb_valid & ~wb_hold_q & ~is_x0(wb_rd);
    fifo_pop    = 1'b0;
    write_reg_d = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_data_d   = rf_data_q;
    if (wb_hold_q && !fifo_empty) begin
      fifo_pop    = 1'b1;
      write_reg_d = 1'b1;
      rf_rd_d     = fifo_head.rd;
      rf_data_d   = fifo_head.data;
    end else if (take_wb) begin
      write_reg_d = 1'b1;
      rf_rd_d     = wb_rd;
      rf_data_d   = wb_data;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      write_reg_d = 1'b1;
      rf_rd_d     = fifo_head.rd;
      rf_data_d   = fifo_head.data;
    end
  end

  // Pending bitmap: issue sets, retirement through the FIFO clears, set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && !is_x0(issue_rd)) set_mask[issue_rd] = 1'b1;
    if (fifo_pop) clr_mask[fifo_head.rd] = 1'b1;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Starvation: count cycles the head waits, saturating; hold once near limit.
  always_comb begin
    if (fifo_empty || fifo_pop)     starve_d = '0;
    else if (starve_q == STARVE_SAT) starve_d = starve_q;
    else                            starve_d = starve_q + 1'b1;
    wb_hold_d = (starve_d >= STARVE_HOLD);
  end

  // State and output registers; reset drops all queued and pending work.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      starve_q    <= '0;
      wb_hold_q   <= 1'b0;
      write_reg_q <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      starve_q    <= starve_d;
      wb_hold_q   <= wb_hold_d;
      write_reg_q <= write_reg_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
    end
  end

  assign stall     = pending_q[rs1] | pending_q[rs2] | pending_q[rd];
  assign wb_hold   = wb_hold_q;
  assign write_reg = write_reg_q;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;

  // The pipeline must never present a writeback while it is being held.
  a_no_wb_while_hold : assert property (@(posedge clk) disable iff (reset)
    !(wb_valid && wb_hold_q));

endmodule
